clock_div_ctrl: RTL and testbench

CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

---
 rtl/clock_div_ctrl.sv | 141 ++++++++++++++
 tb/tb_clock_div_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_ctrl.sv
// Programmable clock divider with a registered square/pulse output, a
// double-buffered configuration interface and graceful stop at period boundaries.
module clock_div_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_pulse,
  input  logic             start,
  input  logic             stop,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [7:0]       period_count
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] cnt_q, cnt_nx;
  logic [WIDTH-1:0] div_q, div_nx;
  logic [WIDTH-1:0] sdiv_q, sdiv_nx;
  logic             pulse_q, pulse_nx;
  logic             spulse_q, spulse_nx;
  logic             stop_q, stop_nx;
  logic             clk_out_nx, tick_nx, busy_nx, ready_nx;
  logic [7:0]       pcount_nx;
  logic             hs;
  logic             last;

  // Divide ratios below 2 cannot form a period with both phases.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    return (d < WIDTH'(2)) ? WIDTH'(2) : d;
  endfunction

  // ceil(d/2) without widening, so d = 2^WIDTH-1 does not overflow.
  function automatic logic [WIDTH-1:0] ceil_half(input logic [WIDTH-1:0] d);
    return (d >> 1) + {{(WIDTH-1){1'b0}}, d[0]};
  endfunction

  assign hs   = cfg_valid & cfg_ready;
  assign last = (cnt_q == div_q - WIDTH'(1));

  always_comb begin
    state_nx   = state_q;
    cnt_nx     = cnt_q;
    div_nx     = div_q;
    pulse_nx   = pulse_q;
    sdiv_nx    = sdiv_q;
    spulse_nx  = spulse_q;
    stop_nx    = stop_q;
    clk_out_nx = 1'b0;
    tick_nx    = 1'b0;
    pcount_nx  = period_count;

    case (state_q)
      IDLE: begin
        stop_nx = 1'b0;
        if (hs) begin
          div_nx   = clamp_div(cfg_div);
          pulse_nx = cfg_pulse;
        end
        if (start && !stop) begin
          state_nx   = RUN;
          cnt_nx     = '0;
          tick_nx    = 1'b1;
          clk_out_nx = 1'b1;
          pcount_nx  = 8'd0;
        end
      end
      default: begin
        stop_nx = stop_q | stop;
        if (last) begin
          // Period boundary: the next period uses the newest configuration.
          if (state_q == PEND) begin
            div_nx   = sdiv_q;
            pulse_nx = spulse_q;
          end else if (hs) begin
            div_nx   = clamp_div(cfg_div);
            pulse_nx = cfg_pulse;
          end
          cnt_nx = '0;
          if (stop_q || stop) begin
            state_nx = IDLE;
            stop_nx  = 1'b0;
          end else begin
            state_nx   = RUN;
            tick_nx    = 1'b1;
            clk_out_nx = 1'b1;
            pcount_nx  = period_count + 8'd1;
          end
        end else begin
          if (state_q == RUN && hs) begin
            sdiv_nx   = clamp_div(cfg_div);
            spulse_nx = cfg_pulse;
            state_nx  = PEND;
          end
          cnt_nx     = cnt_q + WIDTH'(1);
          clk_out_nx = !pulse_q && (cnt_nx < ceil_half(div_q));
        end
      end
    endcase

    busy_nx  = (state_nx != IDLE);
    ready_nx = (state_nx != PEND);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= WIDTH'(2);
      pulse_q      <= 1'b0;
      sdiv_q       <= '0;
      spulse_q     <= 1'b0;
      stop_q       <= 1'b0;
      clk_out      <= 1'b0;
      tick         <= 1'b0;
      busy         <= 1'b0;
      cfg_ready    <= 1'b1;
      period_count <= 8'd0;
    end else begin
      state_q      <= state_nx;
      cnt_q        <= cnt_nx;
      div_q        <= div_nx;
      pulse_q      <= pulse_nx;
      sdiv_q       <= sdiv_nx;
      spulse_q     <= spulse_nx;
      stop_q       <= stop_nx;
      clk_out      <= clk_out_nx;
      tick         <= tick_nx;
      busy         <= busy_nx;
      cfg_ready    <= ready_nx;
      period_count <= pcount_nx;
    end
  end

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl: expected waveforms are derived from the
// divide ratio and mode of each scenario.
module tb_clock_div_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_pulse = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] period_count;

  int errors = 0;
  int checks = 0;

  clock_div_ctrl #(.WIDTH(8)) dut (
    .clk_in(clk_in), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_pulse(cfg_pulse), .start(start), .stop(stop),
    .clk_out(clk_out), .tick(tick), .busy(busy), .period_count(period_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {clk_out, tick, busy} as one 3-bit value
  task automatic chk_out(input string tag, input logic c, input logic t, input logic b);
    chk(tag, int'({clk_out, tick, busy}), int'({c, t, b}));
  endtask

  // Entered at the first cycle of a period; checks n consecutive cycles.
  task automatic run_check(input string tag, input int n, input int d, input logic pulse,
                           input int pc0);
    for (int i = 0; i < n; i++) begin
      int k;
      logic [7:0] pc;
      k  = i % d;
      pc = 8'(pc0 + i / d);
      chk_out(tag, pulse ? (k == 0) : (k < (d + 1) / 2), k == 0, 1'b1);
      chk({tag, "_pc"}, int'(period_count), int'(pc));
      cyc();
    end
  endtask

  task automatic finish_stop();
    int n;
    n = 0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    while (busy === 1'b1 && n < 300) begin
      cyc();
      n++;
    end
    chk("stop_done", int'({busy, clk_out, tick}), 0);
  endtask

  initial begin
    // reset
    cyc();
    chk_out("rst_out", 1'b0, 1'b0, 1'b0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_pc", int'(period_count), 0);
    rst = 1'b1;

    // D=4 square
    cfg_valid = 1'b1; cfg_div = 8'd4; cfg_pulse = 1'b0;
    cyc();
    cfg_valid = 1'b0;
    chk_out("idle_cfg", 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_check("d4", 12, 4, 1'b0, 0);

    // reconfigure to D=6 in mid-period
    chk_out("d4_p3k0", 1'b1, 1'b1, 1'b1);
    cyc();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    chk("rdy_before", int'(cfg_ready), 1);
    cyc();
    cfg_valid = 1'b0;
    chk("rdy_pend2", int'(cfg_ready), 0);
    chk_out("d4_p3k2", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("rdy_pend3", int'(cfg_ready), 0);
    chk_out("d4_p3k3", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("rdy_applied", int'(cfg_ready), 1);
    run_check("d6", 12, 6, 1'b0, 4);

    // stop with a pending D=8 shadow
    stop = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd8;
    cyc();
    stop = 1'b0; cfg_valid = 1'b0;
    for (int k = 1; k < 6; k++) begin
      chk_out("d6_stopping", k < 3, 1'b0, 1'b1);
      cyc();
    end
    chk_out("stopped", 1'b0, 1'b0, 1'b0);
    chk("stopped_rdy", int'(cfg_ready), 1);
    cyc();
    chk_out("idle_quiet", 1'b0, 1'b0, 1'b0);

    // D=8 from the shadow; stop in its first cycle
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("d8_k0", 1'b1, 1'b1, 1'b1);
    chk("d8_pc", int'(period_count), 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int k = 1; k < 8; k++) begin
      chk_out("d8_stopping", k < 4, 1'b0, 1'b1);
      cyc();
    end
    chk_out("d8_stopped", 1'b0, 1'b0, 1'b0);
    cyc();
    chk_out("d8_no_tick", 1'b0, 1'b0, 1'b0);

    // D=5 square, configured and started together
    cfg_valid = 1'b1; cfg_div = 8'd5; cfg_pulse = 1'b0; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    run_check("d5", 10, 5, 1'b0, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("start_ignored", 1'b1, 1'b0, 1'b1);
    chk("start_ign_pc", int'(period_count), 2);
    cyc();
    cyc();
    cyc();
    // acceptance in the last cycle of a period takes effect next period
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_pulse = 1'b0;
    chk("rdy_last", int'(cfg_ready), 1);
    cyc();
    cfg_valid = 1'b0;
    run_check("d3sq", 6, 3, 1'b0, 3);
    chk("rdy_direct", int'(cfg_ready), 1);
    finish_stop();

    // D=3 pulse
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_pulse = 1'b1; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    run_check("d3p", 9, 3, 1'b1, 0);
    finish_stop();

    // stop in IDLE, and start+stop together in IDLE
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk_out("stop_idle", 1'b0, 1'b0, 1'b0);
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk_out("start_stop", 1'b0, 1'b0, 1'b0);

    // cfg_div=0 clamps to 2; period_count wraps after 256 ticks
    cfg_valid = 1'b1; cfg_div = 8'd0; cfg_pulse = 1'b0; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    run_check("d0", 512, 2, 1'b0, 0);
    chk_out("wrap_tick", 1'b1, 1'b1, 1'b1);
    chk("wrap_pc", int'(period_count), 0);
    finish_stop();

    // reset while a configuration is pending
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_pulse = 1'b0; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    chk_out("d3_k0", 1'b1, 1'b1, 1'b1);
    cfg_valid = 1'b1; cfg_div = 8'd7;
    cyc();
    cfg_valid = 1'b0;
    chk("rdy_pend_rst", int'(cfg_ready), 0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk_out("mid_rst_out", 1'b0, 1'b0, 1'b0);
    chk("mid_rst_rdy", int'(cfg_ready), 1);
    chk("mid_rst_pc", int'(period_count), 0);
    cyc();
    chk_out("mid_rst_quiet", 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_check("post_rst_d2", 6, 2, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
